// File: rtl/sdram_if_pkg.sv
// Shared definitions for the SDRAM user-side request/acknowledge interface.
// Used by the responder, the controller and the test top levels.
package sdram_if_pkg;

  localparam int SDRAM_ADDR_W = 22;
  localparam int SDRAM_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    TURN
  } resp_state_t;

endpackage

// File: rtl/resp_mem.sv
// Register-array backing store for the handshake responder.
// Synchronous write port and a registered, resettable read port.
module resp_mem #(
  parameter int DATA_W  = 128,
  parameter int DEPTH_W = 4
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iwe,
  input  logic [DEPTH_W-1:0] iwaddr,
  input  logic [DATA_W-1:0]  iwdata,
  input  logic               ire,
  input  logic [DEPTH_W-1:0] iraddr,
  output logic [DATA_W-1:0]  ordata
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  // NOTE: the array itself is deliberately not reset; only the read register is.
  // Resetting storage would turn a compact array into a wide reset fan-out.
  always_ff @(posedge iclk) begin
    if (iwe) mem[iwaddr] <= iwdata;
  end

  always_ff @(posedge iclk) begin
    if (ireset)   ordata <= '0;
    else if (ire) ordata <= mem[iraddr];
  end

endmodule

// File: rtl/sdram_handshake_responder.sv
// Responder end of the level-request / pulse-acknowledge SDRAM user protocol,
// backed by a small register memory with programmable completion latency.
module sdram_handshake_responder
  import sdram_if_pkg::*;
#(
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int DATA_W     = SDRAM_DATA_W,
  parameter int DEPTH_W    = 4,
  parameter int WR_LATENCY = 4,
  parameter int RD_LATENCY = 6
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iwrite_req,
  input  logic [ADDR_W-1:0] iwrite_address,
  input  logic [DATA_W-1:0] iwrite_data,
  output logic              owrite_ack,
  input  logic              iread_req,
  input  logic [ADDR_W-1:0] iread_address,
  output logic [DATA_W-1:0] oread_data,
  output logic              oread_ack,
  output logic              obusy,
  output logic              oproto_err
);

  localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);

  resp_state_t        state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               wr_ack_d, rd_ack_d, err_d;
  logic               mem_we, mem_re;

  // Upper address bits alias onto the same entry by design.
  logic addr_hi_unused;
  assign addr_hi_unused = ^{iwrite_address[ADDR_W-1:DEPTH_W], iread_address[ADDR_W-1:DEPTH_W]};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    err_d    = oproto_err;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    unique case (state)
      IDLE: begin
        if (iwrite_req) begin
          addr_d  = iwrite_address[DEPTH_W-1:0];
          data_d  = iwrite_data;
          cnt_d   = WR_LOAD;
          state_d = WRITE;
        end else if (iread_req) begin
          addr_d  = iread_address[DEPTH_W-1:0];
          cnt_d   = RD_LOAD;
          state_d = READ;
        end
      end
      WRITE: begin
        if (!iwrite_req) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt == '0) begin
          mem_we   = 1'b1;
          wr_ack_d = 1'b1;
          state_d  = TURN;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      READ: begin
        if (!iread_req) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt == '0) begin
          mem_re   = 1'b1;
          rd_ack_d = 1'b1;
          state_d  = TURN;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A reset edge must never commit a pending transaction to memory.
    if (ireset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      owrite_ack <= 1'b0;
      oread_ack  <= 1'b0;
      obusy      <= 1'b0;
      oproto_err <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      owrite_ack <= wr_ack_d;
      oread_ack  <= rd_ack_d;
      obusy      <= (state_d != IDLE);
      oproto_err <= err_d;
    end
  end

  resp_mem #(
    .DATA_W (DATA_W),
    .DEPTH_W(DEPTH_W)
  ) u_mem (
    .iclk  (iclk),
    .ireset(ireset),
    .iwe   (mem_we),
    .iwaddr(addr_q),
    .iwdata(data_q),
    .ire   (mem_re),
    .iraddr(addr_q),
    .ordata(oread_data)
  );

endmodule

// File: tb/tb_sdram_handshake_responder.sv
// Self-checking bench for sdram_handshake_responder: directed scenarios plus
// randomized traffic compared every cycle against a cycle-count reference model.
module tb_sdram_handshake_responder;
  import sdram_if_pkg::*;

  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 128;
  localparam int DEPTH_W = 4;
  localparam int WR_L    = 4;
  localparam int RD_L    = 6;
  localparam int DEPTH   = 1 << DEPTH_W;

  logic              iclk = 1'b0;
  logic              ireset;
  logic              iwrite_req;
  logic [ADDR_W-1:0] iwrite_address;
  logic [DATA_W-1:0] iwrite_data;
  logic              owrite_ack;
  logic              iread_req;
  logic [ADDR_W-1:0] iread_address;
  logic [DATA_W-1:0] oread_data;
  logic              oread_ack;
  logic              obusy;
  logic              oproto_err;

  always #5 iclk = ~iclk;

  sdram_handshake_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH_W   (DEPTH_W),
    .WR_LATENCY(WR_L),
    .RD_LATENCY(RD_L)
  ) dut (
    .iclk          (iclk),
    .ireset        (ireset),
    .iwrite_req    (iwrite_req),
    .iwrite_address(iwrite_address),
    .iwrite_data   (iwrite_data),
    .owrite_ack    (owrite_ack),
    .iread_req     (iread_req),
    .iread_address (iread_address),
    .oread_data    (oread_data),
    .oread_ack     (oread_ack),
    .obusy         (obusy),
    .oproto_err    (oproto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired without the expected event", name);
  endtask

  // Reference model: tracks the transaction in flight by its accept cycle and
  // decides completion purely from elapsed cycles.
  int                cyc    = 0;
  int                m_kind = 0;   // 0 none, 1 write pending, 2 read pending
  int                m_acc  = 0;
  bit                m_turn = 1'b0;
  int                m_addr = 0;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];
  bit                e_wack = 1'b0, e_rack = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [DATA_W-1:0] e_rdata = '0;
  bit                e_rknown = 1'b1;
  bit                started = 1'b0;

  always @(posedge iclk) begin
    cyc++;
    e_wack = 1'b0;
    e_rack = 1'b0;
    if (ireset === 1'b1) begin
      m_kind   = 0;
      m_turn   = 1'b0;
      e_busy   = 1'b0;
      e_err    = 1'b0;
      e_rdata  = '0;
      e_rknown = 1'b1;
      started  = 1'b1;
    end else if (m_kind != 0) begin
      if ((m_kind == 1 && !iwrite_req) || (m_kind == 2 && !iread_req)) begin
        m_kind = 0;
        e_err  = 1'b1;
        e_busy = 1'b0;
      end else if (cyc - m_acc == ((m_kind == 1) ? WR_L : RD_L)) begin
        if (m_kind == 1) begin
          m_mem[m_addr]   = m_data;
          m_known[m_addr] = 1'b1;
          e_wack          = 1'b1;
        end else begin
          e_rdata  = m_mem[m_addr];
          e_rknown = m_known[m_addr];
          e_rack   = 1'b1;
        end
        m_kind = 0;
        m_turn = 1'b1;
        e_busy = 1'b1;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
      e_busy = 1'b0;
    end else if (iwrite_req) begin
      m_kind = 1;
      m_acc  = cyc;
      m_addr = int'(iwrite_address) % DEPTH;
      m_data = iwrite_data;
      e_busy = 1'b1;
    end else if (iread_req) begin
      m_kind = 2;
      m_acc  = cyc;
      m_addr = int'(iread_address) % DEPTH;
      e_busy = 1'b1;
    end
  end

  always @(negedge iclk) begin
    if (started) begin
      check("owrite_ack", owrite_ack, e_wack);
      check("oread_ack", oread_ack, e_rack);
      check("obusy", obusy, e_busy);
      check("oproto_err", oproto_err, e_err);
      if (e_rknown) check("oread_data", oread_data, e_rdata);
    end
  end

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (obusy !== 1'b0) begin
      if (n == 50) begin
        timeout("wait_idle");
        return;
      end
      @(negedge iclk);
      n++;
    end
  endtask

  // lat is the number of cycles from the accept edge to the ack edge, -1 if none.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int abort_k, output int lat);
    wait_idle();
    iwrite_address = a;
    iwrite_data    = d;
    iwrite_req     = 1'b1;
    lat            = -1;
    for (int k = 1; k <= WR_L + 4; k++) begin
      @(negedge iclk);
      if (k == 1) begin
        iwrite_address = ADDR_W'($urandom);
        iwrite_data    = rand_data();
      end
      if (owrite_ack === 1'b1) begin
        lat        = k - 1;
        iwrite_req = 1'b0;
        return;
      end
      if (k == abort_k) begin
        iwrite_req = 1'b0;
        repeat (2) @(negedge iclk);
        return;
      end
    end
    iwrite_req = 1'b0;
    timeout("write_ack");
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int abort_k, output int lat);
    wait_idle();
    iread_address = a;
    iread_req     = 1'b1;
    lat           = -1;
    for (int k = 1; k <= RD_L + 4; k++) begin
      @(negedge iclk);
      if (k == 1) iread_address = ADDR_W'($urandom);
      if (oread_ack === 1'b1) begin
        lat       = k - 1;
        iread_req = 1'b0;
        return;
      end
      if (k == abort_k) begin
        iread_req = 1'b0;
        repeat (2) @(negedge iclk);
        return;
      end
    end
    iread_req = 1'b0;
    timeout("read_ack");
  endtask

  task automatic do_both(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [ADDR_W-1:0] ra, output int wlat, output int rlat);
    wait_idle();
    iwrite_address = wa;
    iwrite_data    = wd;
    iread_address  = ra;
    iwrite_req     = 1'b1;
    iread_req      = 1'b1;
    wlat           = -1;
    rlat           = -1;
    for (int k = 1; k <= WR_L + RD_L + 8; k++) begin
      @(negedge iclk);
      if (owrite_ack === 1'b1) begin
        wlat       = k - 1;
        iwrite_req = 1'b0;
      end
      if (oread_ack === 1'b1) begin
        rlat      = k - 1;
        iread_req = 1'b0;
        return;
      end
    end
    iwrite_req = 1'b0;
    iread_req  = 1'b0;
    timeout("both_ack");
  endtask

  task automatic reset_during_read(input logic [ADDR_W-1:0] a, input int k);
    wait_idle();
    iread_address = a;
    iread_req     = 1'b1;
    repeat (k) @(negedge iclk);
    ireset    = 1'b1;
    iread_req = 1'b0;
    @(negedge iclk);
    ireset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wl, rl, lat, r;
    ireset         = 1'b1;
    iwrite_req     = 1'b0;
    iread_req      = 1'b0;
    iwrite_address = '0;
    iwrite_data    = '0;
    iread_address  = '0;
    repeat (2) @(negedge iclk);
    check("reset_rdata", oread_data, '0);
    check("reset_busy", obusy, 1'b0);
    ireset = 1'b0;
    @(negedge iclk);

    // 1: single write, ack latency and return to idle
    do_write(22'h2, 128'hA5, 0, lat);
    check("t1_wr_latency", lat, 4);
    @(negedge iclk);
    check("t1_ack_single", owrite_ack, 1'b0);
    check("t1_idle", obusy, 1'b0);

    // 2: read back and hold
    do_read(22'h2, 0, lat);
    check("t2_rd_latency", lat, 6);
    check("t2_rdata", oread_data, 128'hA5);
    repeat (3) @(negedge iclk);
    check("t2_rdata_held", oread_data, 128'hA5);

    // 3: simultaneous requests, write wins and read sees it
    do_both(22'h1, 128'h3C, 22'h1, wl, rl);
    check("t3_wr_latency", wl, 4);
    check("t3_rd_after", rl, 12);
    check("t3_rdata", oread_data, 128'h3C);

    // 4: aborted write leaves memory untouched and flags the error
    do_write(22'h2, 128'hFF, 2, lat);
    check("t4_no_ack", (lat < 0), 1'b1);
    check("t4_err", oproto_err, 1'b1);
    repeat (3) @(negedge iclk);
    check("t4_err_sticky", oproto_err, 1'b1);
    do_read(22'h2, 0, lat);
    check("t4_old_value", oread_data, 128'hA5);

    // 5: reset in the middle of a read
    reset_during_read(22'h1, 3);
    check("t5_busy", obusy, 1'b0);
    check("t5_rdata", oread_data, '0);
    check("t5_no_ack", oread_ack, 1'b0);
    check("t5_err_clear", oproto_err, 1'b0);

    // 6: aliased addresses share one entry
    do_write(22'h000003, 128'h11, 0, lat);
    do_write(22'h000013, 128'h22, 0, lat);
    do_read(22'h3, 0, lat);
    check("t6_alias", oread_data, 128'h22);

    // Random traffic over a fully populated memory
    for (int i = 0; i < DEPTH; i++)
      do_write(ADDR_W'(($urandom << DEPTH_W) | i), rand_data(), 0, lat);
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 15);
      if (r <= 5)       do_write(ADDR_W'($urandom), rand_data(), 0, lat);
      else if (r <= 10) do_read(ADDR_W'($urandom), 0, lat);
      else if (r <= 12) do_both(ADDR_W'($urandom), rand_data(), ADDR_W'($urandom), wl, rl);
      else if (r == 13) do_write(ADDR_W'($urandom), rand_data(), $urandom_range(1, WR_L), lat);
      else if (r == 14) do_read(ADDR_W'($urandom), $urandom_range(1, RD_L), lat);
      else              reset_during_read(ADDR_W'($urandom), $urandom_range(1, RD_L));
    end

    repeat (4) @(negedge iclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
